// File: rtl/sic_jr_dispatch.sv
// Issue-to-JR-sub-SIC dispatcher: one holding register feeding NUM_UNITS units through a
// round-robin arbiter, delivering each packet as a registered one-hot valid pulse.
module sic_jr_dispatch #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned PKT_W     = 96,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [PKT_W-1:0]     up_pkt,
    input  logic                 flush,
    input  logic [NUM_UNITS-1:0] unit_req,
    output logic [NUM_UNITS-1:0] unit_valid,
    output logic [PKT_W-1:0]     unit_pkt,
    output logic                 hold_valid_o,
    output logic [CNT_W-1:0]     dispatch_cnt
);

    localparam int unsigned PtrW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                 hold_valid_q;
    logic [PKT_W-1:0]     hold_pkt_q;
    logic [NUM_UNITS-1:0] unit_valid_q;
    logic [PKT_W-1:0]     unit_pkt_q;
    logic [PtrW-1:0]      rr_ptr_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [NUM_UNITS-1:0] eligible;
    logic [NUM_UNITS-1:0] grant_onehot;
    logic [PtrW-1:0]      grant;
    logic [PtrW-1:0]      rr_next;
    logic                 grant_found;
    logic                 dispatch_now;
    logic                 accept;

    // A unit whose pulse is currently high must not be granted again, even if it keeps req high.
    assign eligible = unit_req & ~unit_valid_q;

    always_comb begin
        logic [31:0] idx;
        grant       = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_UNITS) begin
                idx = idx - NUM_UNITS;
            end
            if (!grant_found && eligible[idx[PtrW-1:0]]) begin
                grant_found = 1'b1;
                grant       = idx[PtrW-1:0];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            grant_onehot[i] = (grant == PtrW'(i));
        end
    end

    always_comb begin
        if (NUM_UNITS == 1 || grant == PtrW'(NUM_UNITS - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = grant + PtrW'(1);
        end
    end

    assign dispatch_now = hold_valid_q && grant_found && !flush;
    assign up_ready     = !flush && (!hold_valid_q || dispatch_now);
    assign accept       = up_valid && up_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_pkt_q   <= '0;
            unit_valid_q <= '0;
            unit_pkt_q   <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            unit_valid_q <= dispatch_now ? grant_onehot : '0;
            if (dispatch_now) begin
                unit_pkt_q <= hold_pkt_q;
                rr_ptr_q   <= rr_next;
                cnt_q      <= cnt_q + CNT_W'(1);
            end
            // Flush wins; otherwise a new accept overwrites the slot just freed by dispatch.
            if (flush) begin
                hold_valid_q <= 1'b0;
            end else if (accept) begin
                hold_valid_q <= 1'b1;
                hold_pkt_q   <= up_pkt;
            end else if (dispatch_now) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign unit_valid   = unit_valid_q;
    assign unit_pkt     = unit_pkt_q;
    assign hold_valid_o = hold_valid_q;
    assign dispatch_cnt = cnt_q;

endmodule
